pht_update_queue: RTL and testbench
===================================

Name: pht_update_queue

Overview:
- Writer side of the gshare PHT; the fetch-stage predictor is the reader.
- Accepts one resolved branch result per cycle from the integer backend and computes the new 2-bit saturating counter from the carried prevValue.
- Buffers the update in an in-order FIFO and drains it into the single PHT write port only when fetch grants the port.
- Provides a youngest-match forwarding lookup so fetch sees counter values still waiting in the queue.

Parameters:
QUEUE_DEPTH, 32, FIFO entries; power of two, at least 2
PC_WIDTH, 32, branch address width
INDEX_WIDTH, 11, PHT index width (log2 of PHT entry count)
GHR_WIDTH, 10, global history width; must be at most INDEX_WIDTH
INSN_OFFSET, 2, low PC bits dropped before indexing

Ports:
clk  in  1  clock
rstN  in  1  reset, asynchronous, active-low
resultValid  in  1  branch result offered
resultReady  out  1  queue can accept a result
brAddr  in  PC_WIDTH  address of the executed branch
isCondBr  in  1  branch is conditional
execTaken  in  1  resolved direction
globalHistory  in  GHR_WIDTH  history used at prediction time
phtPrevValue  in  2  counter value read at prediction time
phtWE  out  1  write request to the PHT
phtWA  out  INDEX_WIDTH  PHT write index
phtWV  out  2  PHT write value
phtWriteGrant  in  1  fetch releases the PHT port this cycle
lookupIndex  in  INDEX_WIDTH  fetch PHT read index
fwdHit  out  1  a pending entry matches lookupIndex
fwdValue  out  2  counter value of the youngest matching entry
count  out  log2(QUEUE_DEPTH)+1  occupancy
empty  out  1  count == 0
full  out  1  count == QUEUE_DEPTH

Behaviour:
- Reset (rstN low, asynchronous): head, tail and count go to 0, and all entry valid bits clear. Outputs during reset are resultReady=1, phtWE=0, fwdHit=0, empty=1, full=0, count=0, phtWA=0, phtWV=0, fwdValue=0. A reset mid-operation discards every pending update.
- Index: idx = brAddr[INDEX_WIDTH+INSN_OFFSET-1:INSN_OFFSET] XOR (globalHistory << (INDEX_WIDTH-GHR_WIDTH)), truncated to INDEX_WIDTH.
- New value: if execTaken, newV = (prev==3) ? 3 : prev+1. Otherwise newV = (prev==0) ? 0 : prev-1. This is 2-bit saturating arithmetic with no wrap.
- Handshake: a result is accepted when resultValid && resultReady. resultReady = !full, computed from registered state only; it does not depend on a same-cycle pop.
- Enqueue: an accepted result is written to the tail entry {idx, newV} and tail advances at the edge, only if isCondBr=1 and newV != prev.
- Silent drop: an accepted result with isCondBr=0 or newV==prev is consumed with no state change.
- Drain: phtWE = !empty, with phtWA/phtWV driven combinationally from the head entry. When phtWE && phtWriteGrant, the write is done that cycle and head advances at the edge. With phtWriteGrant low, head, phtWA and phtWV hold stable.
- Latency: a result enqueued at edge N reaches phtWE=1 in the cycle after edge N at the earliest. There is no empty-bypass.
- Simultaneous push and pop: both pointers move and count is unchanged. This is legal at count==QUEUE_DEPTH only if resultReady was already high, which by definition cannot happen when full, so a full queue needs a pop before it accepts again.
- Pointers: wrap modulo QUEUE_DEPTH. count distinguishes full from empty when head==tail.
- Ordering: strictly FIFO, so updates to the same index reach the PHT in acceptance order.
- Forwarding: combinational.
  - fwdHit=1 if any valid entry has idx==lookupIndex; fwdValue is the value of the youngest such entry (closest to tail).
  - The head entry being popped this cycle still participates.
  - A result being enqueued in the same cycle does not.
  - With no match, fwdHit=0 and fwdValue=0.

Test Plan:
- Reset then single update: brAddr=0x0000_0104, globalHistory=0, prev=1, execTaken=1 -> next cycle phtWE=1, phtWA=0x041, phtWV=2. With grant=1 that cycle, empty=1 afterwards.
- Saturation and silent drop: prev=3 with taken, and prev=0 with not-taken -> accepted, count stays 0, phtWE stays 0. isCondBr=0 -> also dropped.
- Grant stall and fill: grant=0, then 32 updates -> full=1, resultReady=0, and the 33rd offer is held. Grant one cycle -> head (first) entry written, resultReady=1 next cycle.
- Ordering and forwarding: enqueue index 0x10 with value 2, then index 0x10 with value 3, grant=0. lookupIndex=0x10 -> fwdHit=1, fwdValue=3. Drain -> PHT sees 2 then 3. lookupIndex=0x11 -> fwdHit=0.
- Wrap and simultaneous push/pop: 40 back-to-back updates with grant=1 continuously -> count stays at most 1, all 40 writes in order, pointers wrap.
- Asynchronous reset with 5 entries pending -> outputs take their reset values immediately; no phtWE after release.

Source files
------------

// File: rtl/pht_update_queue.sv
// Writer side of the gshare PHT: computes saturating counter updates, buffers them
// in an in-order FIFO drained on fetch grant, and forwards pending values to fetch.
module pht_update_queue #(
    parameter int QUEUE_DEPTH = 32,
    parameter int PC_WIDTH    = 32,
    parameter int INDEX_WIDTH = 11,
    parameter int GHR_WIDTH   = 10,
    parameter int INSN_OFFSET = 2
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         resultValid,
    output logic                         resultReady,
    input  logic [PC_WIDTH-1:0]          brAddr,
    input  logic                         isCondBr,
    input  logic                         execTaken,
    input  logic [GHR_WIDTH-1:0]         globalHistory,
    input  logic [1:0]                   phtPrevValue,
    output logic                         phtWE,
    output logic [INDEX_WIDTH-1:0]       phtWA,
    output logic [1:0]                   phtWV,
    input  logic                         phtWriteGrant,
    input  logic [INDEX_WIDTH-1:0]       lookupIndex,
    output logic                         fwdHit,
    output logic [1:0]                   fwdValue,
    output logic [$clog2(QUEUE_DEPTH):0] count,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    logic [INDEX_WIDTH-1:0] ent_idx [QUEUE_DEPTH];
    logic [1:0]             ent_val [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] ent_valid;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [PTR_W:0]         occ;

    logic [INDEX_WIDTH-1:0] new_idx;
    logic [INDEX_WIDTH-1:0] ghr_ext;
    logic [1:0]             new_val;
    logic                   push;
    logic                   pop;

    always_comb begin
        ghr_ext = INDEX_WIDTH'(globalHistory) << (INDEX_WIDTH - GHR_WIDTH);
        new_idx = brAddr[INDEX_WIDTH+INSN_OFFSET-1:INSN_OFFSET] ^ ghr_ext;
    end

    always_comb begin
        new_val = phtPrevValue;
        if (execTaken) begin
            if (phtPrevValue != 2'd3) new_val = phtPrevValue + 2'd1;
        end else begin
            if (phtPrevValue != 2'd0) new_val = phtPrevValue - 2'd1;
        end
    end

    assign count       = occ;
    assign empty       = (occ == '0);
    assign full        = (occ == (PTR_W+1)'(QUEUE_DEPTH));
    assign resultReady = !full;

    // Results that leave the counter unchanged, or are unconditional, are consumed silently.
    assign push = resultValid && resultReady && isCondBr && (new_val != phtPrevValue);
    assign pop  = phtWE && phtWriteGrant;

    assign phtWE = !empty;
    assign phtWA = empty ? '0 : ent_idx[head];
    assign phtWV = empty ? '0 : ent_val[head];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head      <= '0;
            tail      <= '0;
            occ       <= '0;
            ent_valid <= '0;
        end else begin
            if (pop) begin
                head            <= head + PTR_W'(1);
                ent_valid[head] <= 1'b0;
            end
            if (push) begin
                tail            <= tail + PTR_W'(1);
                ent_valid[tail] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + (PTR_W+1)'(1);
                2'b01:   occ <= occ - (PTR_W+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_idx[tail] <= new_idx;
            ent_val[tail] <= new_val;
        end
    end

    // Scan oldest to youngest so the last match seen is the entry nearest the tail.
    always_comb begin
        logic [PTR_W-1:0] pos;
        fwdHit   = 1'b0;
        fwdValue = '0;
        pos      = '0;
        for (int unsigned k = 0; k < QUEUE_DEPTH; k++) begin
            pos = head + PTR_W'(k);
            if (ent_valid[pos] && (ent_idx[pos] == lookupIndex)) begin
                fwdHit   = 1'b1;
                fwdValue = ent_val[pos];
            end
        end
    end

endmodule

// File: tb/tb_pht_update_queue.sv
// Scoreboard bench for pht_update_queue: expected PHT writes are queued at issue
// and checked by a monitor whenever the DUT performs a granted write.
module tb_pht_update_queue;

    logic        clk;
    logic        rstN;
    logic        resultValid;
    logic        resultReady;
    logic [31:0] brAddr;
    logic        isCondBr;
    logic        execTaken;
    logic [9:0]  globalHistory;
    logic [1:0]  phtPrevValue;
    logic        phtWE;
    logic [10:0] phtWA;
    logic [1:0]  phtWV;
    logic        phtWriteGrant;
    logic [10:0] lookupIndex;
    logic        fwdHit;
    logic [1:0]  fwdValue;
    logic [5:0]  count;
    logic        empty;
    logic        full;

    int vectors;
    int miscompares;
    logic [12:0] sb [$];

    pht_update_queue #(
        .QUEUE_DEPTH(32),
        .PC_WIDTH(32),
        .INDEX_WIDTH(11),
        .GHR_WIDTH(10),
        .INSN_OFFSET(2)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .resultValid(resultValid),
        .resultReady(resultReady),
        .brAddr(brAddr),
        .isCondBr(isCondBr),
        .execTaken(execTaken),
        .globalHistory(globalHistory),
        .phtPrevValue(phtPrevValue),
        .phtWE(phtWE),
        .phtWA(phtWA),
        .phtWV(phtWV),
        .phtWriteGrant(phtWriteGrant),
        .lookupIndex(lookupIndex),
        .fwdHit(fwdHit),
        .fwdValue(fwdValue),
        .count(count),
        .empty(empty),
        .full(full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] ref_idx(input logic [31:0] a, input logic [9:0] g);
        logic [31:0] t;
        t = (a >> 2) ^ ({22'd0, g} << 1);
        return t[10:0];
    endfunction

    function automatic logic [1:0] ref_val(input logic [1:0] p, input logic taken);
        if (taken) return (p == 2'd3) ? 2'd3 : p + 2'd1;
        return (p == 2'd0) ? 2'd0 : p - 2'd1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one result; it is accepted at the first edge where resultReady is high.
    task automatic send(input logic [31:0] a, input logic [9:0] g, input logic [1:0] p,
                        input logic taken, input logic cond);
        int w;
        logic [1:0] nv;
        brAddr        = a;
        globalHistory = g;
        phtPrevValue  = p;
        execTaken     = taken;
        isCondBr      = cond;
        resultValid   = 1'b1;
        w = 0;
        @(negedge clk);
        while (!resultReady && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!resultReady) begin
            chk("accept_timeout", 0, 1);
        end else begin
            nv = ref_val(p, taken);
            if (cond && nv != p) sb.push_back({ref_idx(a, g), nv});
        end
        @(posedge clk);
        #1 resultValid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        phtWriteGrant = 1'b1;
        while (!empty && w < 100) begin
            @(posedge clk);
            #1 w++;
        end
        phtWriteGrant = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, resultReady, 1);
        chk({tag, "_we"}, phtWE, 0);
        chk({tag, "_fwdhit"}, fwdHit, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_wa"}, phtWA, 0);
        chk({tag, "_wv"}, phtWV, 0);
        chk({tag, "_fwdval"}, fwdValue, 0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rstN          = 1'b0;
        resultValid   = 1'b0;
        brAddr        = '0;
        isCondBr      = 1'b0;
        execTaken     = 1'b0;
        globalHistory = '0;
        phtPrevValue  = '0;
        phtWriteGrant = 1'b0;
        lookupIndex   = '0;

        fork
            forever begin
                logic [12:0] e;
                @(negedge clk);
                if (rstN && phtWE && phtWriteGrant) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_write", {phtWA, phtWV}, 0);
                        if (phtWA == 0 && phtWV == 0) chk("unexpected_write_we", phtWE, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("pht_write", {phtWA, phtWV}, e);
                    end
                end
            end
        join_none

        // Reset state
        #12;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rstN = 1'b1;

        // Single update: 0x104 -> idx 0x041, 1 -> 2
        send(32'h0000_0104, 10'd0, 2'd1, 1'b1, 1'b1);
        chk("single_we", phtWE, 1);
        chk("single_wa", phtWA, 11'h041);
        chk("single_wv", phtWV, 2);
        phtWriteGrant = 1'b1;
        @(posedge clk);
        #1 phtWriteGrant = 1'b0;
        chk("single_empty_after", empty, 1);

        // Saturation and silent drops
        send(32'h0000_0200, 10'd0, 2'd3, 1'b1, 1'b1);
        chk("sat_hi_count", count, 0);
        chk("sat_hi_we", phtWE, 0);
        send(32'h0000_0200, 10'd0, 2'd0, 1'b0, 1'b1);
        chk("sat_lo_count", count, 0);
        chk("sat_lo_we", phtWE, 0);
        send(32'h0000_0300, 10'd0, 2'd1, 1'b1, 1'b0);
        chk("uncond_count", count, 0);
        chk("uncond_we", phtWE, 0);

        // Grant stall and fill
        for (int i = 0; i < 32; i++) send(32'h0000_1000 + 32'(i * 4), 10'd0, 2'd1, 1'b1, 1'b1);
        chk("fill_full", full, 1);
        chk("fill_ready", resultReady, 0);
        chk("fill_count", count, 32);
        chk("fill_head_wa", phtWA, 11'h400);
        brAddr = 32'h0000_2000; globalHistory = 10'd0; phtPrevValue = 2'd2;
        execTaken = 1'b1; isCondBr = 1'b1; resultValid = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("held_count", count, 32);
        phtWriteGrant = 1'b1;
        @(posedge clk);
        #1 phtWriteGrant = 1'b0;
        chk("pop_ready", resultReady, 1);
        chk("pop_count", count, 31);
        chk("pop_head_wa", phtWA, 11'h401);
        send(32'h0000_2000, 10'd0, 2'd2, 1'b1, 1'b1);
        chk("refill_count", count, 32);
        drain();

        // Ordering and youngest-match forwarding on idx 0x10
        send(32'h0000_0040, 10'd0, 2'd1, 1'b1, 1'b1);
        send(32'h0000_0040, 10'd0, 2'd2, 1'b1, 1'b1);
        lookupIndex = 11'h010;
        #1 chk("fwd_hit", fwdHit, 1);
        chk("fwd_youngest", fwdValue, 3);
        lookupIndex = 11'h011;
        #1 chk("fwd_miss_hit", fwdHit, 0);
        chk("fwd_miss_val", fwdValue, 0);
        lookupIndex = 11'h010;
        phtWriteGrant = 1'b1;
        @(posedge clk);
        #1 chk("fwd_popping_hit", fwdHit, 1);
        chk("fwd_popping_val", fwdValue, 3);
        @(posedge clk);
        #1 phtWriteGrant = 1'b0;
        chk("fwd_after_drain", fwdHit, 0);
        chk("order_sb_empty", sb.size(), 0);

        // Wrap with simultaneous push/pop
        phtWriteGrant = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(32'h0000_8000 + 32'(i * 4), 10'(i * 7), 2'(i % 3), 1'b1, 1'b1);
            chk("wrap_count_le1", int'(count <= 1), 1);
        end
        drain();

        // Asynchronous reset with pending entries
        for (int i = 0; i < 5; i++) send(32'h0000_0500 + 32'(i * 4), 10'd3, 2'd1, 1'b0, 1'b1);
        chk("pre_reset_count", count, 5);
        lookupIndex = ref_idx(32'h0000_0500, 10'd3);
        #1 chk("pre_reset_fwd", fwdHit, 1);
        #2 rstN = 1'b0;
        sb.delete();
        #1 chk_reset_outputs("async_reset");
        @(posedge clk);
        #1 rstN = 1'b1;
        phtWriteGrant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_reset_we", phtWE, 0);
        end
        phtWriteGrant = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
